sram_playback_reader: RTL and testbench
=======================================

Name: sram_playback_reader

Overview:
- Read-side counterpart to the keypad recording path: that path writes 4-bit key codes into the 16-entry SRAM with RW=1 and CE=1; this block reads them back in address order and replays them.
- Drives the SRAM port with CE=1 and RW=0, fetches one code per step, and emits Bin/EN to the piano tone generator for a fixed note length, followed by a silent gap.
- Sits between the SRAM read port and the piano tone generator; a playback-mode mux ahead of the tone generator selects it.

Parameters:
- ADDR_W, 4, SRAM address width; depth = 2^ADDR_W.
- NOTE_CYCLES, 16, cycles EN is held per note or rest step (>=1).
- GAP_CYCLES, 4, silent cycles between steps (>=1).
- SRAM_LATENCY, 1, cycles from the CE read cycle to valid Din (>=1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  level; sampled in IDLE only; begins playback at address 0.
- Stop  in  1  level; synchronous abort from any non-IDLE state.
- Loop  in  1  1 = restart at address 0 on end-of-sequence or address wrap.
- Din  in  4  SRAM read data (stored key code).
- Addr  out  ADDR_W  SRAM address.
- CE  out  1  SRAM chip enable; high exactly one cycle per fetch.
- RW  out  1  SRAM read/write select; this block drives it 0 at all times (read).
- Bin  out  4  key code to the tone generator.
- EN  out  1  tone generator enable.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when playback finishes.

Behaviour:
- Reset: the synchronous, active-high RST forces state IDLE and drives Addr=0, CE=0, RW=0, Bin=0, EN=0, Busy=0, Done=0 on the next CLK edge. RST mid-operation aborts immediately; no Done pulse is produced.
- States: IDLE, READ, WAIT, NOTE, REST, GAP, DONE.
- IDLE: Start=1 -> READ with Addr=0.
- READ: lasts 1 cycle with CE=1, RW=0 and Addr stable -> WAIT.
- WAIT: lasts SRAM_LATENCY cycles; Din is captured into code_q on the last WAIT edge. Decode:
  - code 0-11 -> NOTE.
  - code 12-14 -> REST.
  - code 15 (end marker) -> end handling.
- NOTE: lasts NOTE_CYCLES cycles with EN=1 and Bin=code_q -> GAP.
- REST: lasts NOTE_CYCLES cycles with EN=0; Bin holds its previous value -> GAP.
- GAP: lasts GAP_CYCLES cycles with EN=0.
  - If Addr < 2^ADDR_W-1: Addr+1 -> READ.
  - If Addr = 2^ADDR_W-1: end handling.
- End handling:
  - Loop=1: Addr=0 -> READ.
  - Loop=0: -> DONE.
- DONE: lasts 1 cycle with Done=1, Busy=1 -> IDLE (Busy=0).
- CE is 0 in all states except READ. RW is never 1.
- Start is ignored outside IDLE. Start held high through DONE causes a new playback on the first IDLE cycle.
- Stop=1 in any non-IDLE state -> IDLE next edge: EN=0, CE=0, Addr=0, and Done pulses 1 cycle with that transition. Stop and Start high together in IDLE: Stop wins and the block stays IDLE.
- Loop is sampled only at end handling.
- Step period for NOTE or REST steps = 1 + SRAM_LATENCY + NOTE_CYCLES + GAP_CYCLES cycles (defaults: 22).
- Address arithmetic is unsigned modulo 2^ADDR_W; no out-of-range addresses are generated.

Test Plan:
- Basic replay: SRAM[0..2] = 3, 7, 11; SRAM[3] = 15; Loop=0; Start pulse. Required response:
  - CE pulses at Addr 0, 1, 2, 3, 22 cycles apart.
  - EN high 16 cycles each with Bin = 3, 7, 11.
  - Done pulse 1 cycle after the fetch at Addr 3 decodes; RW=0 throughout.
- Rest code: SRAM[0]=12, SRAM[1]=5, SRAM[2]=15. Required response: EN stays 0 for the first 16-cycle step; then EN=1 with Bin=5; then Done.
- Full wrap: all 16 entries = 2, Loop=0. Required response: 16 notes with Addr 0..15, then Done; Addr never exceeds 15. Repeat with Loop=1: Addr returns to 0 after 15, Done never asserts, Busy stays 1.
- Stop mid-note: assert Stop at cycle 5 of NOTE. Required response: next edge EN=0, Addr=0, state IDLE, Done=1 for 1 cycle, Busy=0 afterward.
- Reset mid-operation: assert RST during WAIT. Required response: next edge all outputs 0 and no Done pulse; a later Start replays from Addr 0.
- Start/Stop priority and latency: Start and Stop both 1 in IDLE -> no CE pulse. Start while Busy -> ignored, sequence timing unchanged. With SRAM_LATENCY=2: WAIT lasts 2 cycles and the code captured equals Din on the second WAIT edge.

Source files
------------

// File: rtl/sram_playback_reader.sv
// sram_playback_reader: reads recorded 4-bit key codes from SRAM in address order
// and replays them to the tone generator as timed notes, rests and gaps.
module sram_playback_reader #(
    parameter int ADDR_W       = 4,
    parameter int NOTE_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int SRAM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Loop,
    input  logic [3:0]        Din,
    output logic [ADDR_W-1:0] Addr,
    output logic              CE,
    output logic              RW,
    output logic [3:0]        Bin,
    output logic              EN,
    output logic              Busy,
    output logic              Done
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, NOTE, REST, GAP, DONE} state_t;
    localparam int CW = $clog2(NOTE_CYCLES + GAP_CYCLES + SRAM_LATENCY + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SRAM_LATENCY - 1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] addr_n;
    logic [3:0] bin_n;
    logic last, fin, abort;
    always_comb begin
        last = (state == WAIT) ? cnt == WAIT_LAST : (state == GAP) ? cnt == GAP_LAST : cnt == NOTE_LAST;
        fin = last && ((state == WAIT && Din == 4'hf) || (state == GAP && Addr == ADDR_MAX));
        abort = Stop && state != IDLE;
        nxt = state;
        addr_n = Addr;
        bin_n = Bin;
        case (state)
            IDLE: nxt = (Start && !Stop) ? READ : IDLE;
            READ: nxt = WAIT;
            WAIT: if (last) begin
                nxt = (Din >= 4'd12) ? REST : NOTE;
                bin_n = (Din >= 4'd12) ? Bin : Din;
            end
            NOTE, REST: nxt = last ? GAP : state;
            GAP: if (last) begin
                nxt = READ;
                addr_n = Addr + 1'b1;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // end marker or last address: restart or finish, always from address 0
        if (fin) begin
            nxt = Loop ? READ : DONE;
            addr_n = '0;
        end
        if (abort) begin
            nxt = IDLE;
            addr_n = '0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            Addr <= '0;
            Bin <= '0;
            Done <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? '0 : cnt + 1'b1;
            Addr <= addr_n;
            Bin <= bin_n;
            Done <= (nxt == DONE) || abort;
        end
    end
    assign CE = state == READ;
    assign RW = 1'b0;
    assign EN = state == NOTE;
    assign Busy = state != IDLE;
endmodule

// File: tb/tb_sram_playback_reader.sv
// tb_sram_playback_reader: table-driven and randomized replay checks against a
// step-timeline model, plus hand-written stop/reset/priority sequences.
module tb_sram_playback_reader;
    localparam int NC = 16;
    localparam int GC = 4;
    logic CLK = 1'b0;
    logic RST, Start1, Start2, Stop, Loop;
    logic [3:0] Din1, Din2, Bin1, Bin2, Addr1, Addr2, p2a;
    logic CE1, RW1, EN1, Busy1, Done1, CE2, RW2, EN2, Busy2, Done2;
    logic [3:0] mem [16];
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic ce;
        logic rw;
        logic en;
        logic [3:0] bin;
        logic busy;
        logic done;
    } obs_t;
    typedef struct {
        obs_t o;
        logic ca;
        logic cb;
    } exp_t;
    typedef struct {
        logic [63:0] prog;
        int ce_n;
        int en_n;
        int dn_n;
    } vec_t;

    obs_t obs1, obs2;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    sram_playback_reader dut1 (
        .CLK(CLK), .RST(RST), .Start(Start1), .Stop(Stop), .Loop(Loop), .Din(Din1),
        .Addr(Addr1), .CE(CE1), .RW(RW1), .Bin(Bin1), .EN(EN1), .Busy(Busy1), .Done(Done1)
    );
    sram_playback_reader #(.SRAM_LATENCY(2)) dut2 (
        .CLK(CLK), .RST(RST), .Start(Start2), .Stop(Stop), .Loop(Loop), .Din(Din2),
        .Addr(Addr2), .CE(CE2), .RW(RW2), .Bin(Bin2), .EN(EN2), .Busy(Busy2), .Done(Done2)
    );

    // SRAM read ports: one-cycle and two-cycle latency
    always_ff @(posedge CLK) begin
        if (CE1) Din1 <= mem[Addr1];
        if (CE2) p2a <= mem[Addr2];
        Din2 <= p2a;
    end

    assign obs1 = {Addr1, CE1, RW1, EN1, Bin1, Busy1, Done1};
    assign obs2 = {Addr2, CE2, RW2, EN2, Bin2, Busy2, Done2};

    function automatic exp_t mk(logic [3:0] a, logic ce, logic en, logic [3:0] b,
                                logic busy, logic dn, logic ca, logic cb);
        exp_t e;
        e.o = {a, ce, 1'b0, en, b, busy, dn};
        e.ca = ca;
        e.cb = cb;
        return e;
    endfunction

    // Expected per-cycle outputs after the Start edge, walked step by step from memory.
    function automatic void build(int lat, logic lp, int cap);
        int a;
        logic [3:0] b, c;
        logic seen;
        a = 0;
        b = 4'd0;
        seen = 1'b0;
        exp_q.delete();
        while (exp_q.size() < cap) begin
            exp_q.push_back(mk(4'(a), 1, 0, b, 1, 0, 1, 0));
            repeat (lat) exp_q.push_back(mk(4'(a), 0, 0, b, 1, 0, 1, 0));
            c = mem[a];
            if (c != 4'd15) begin
                if (c < 4'd12) begin
                    b = c;
                    seen = 1'b1;
                end
                repeat (NC) exp_q.push_back(mk(4'(a), 0, c < 4'd12, b, 1, 0, 1, seen));
                repeat (GC) exp_q.push_back(mk(4'(a), 0, 0, b, 1, 0, 1, 0));
            end
            if (c == 4'd15 || a == 15) begin
                if (!lp) begin
                    exp_q.push_back(mk(4'd0, 0, 0, b, 1, 1, 0, 0));
                    exp_q.push_back(mk(4'd0, 0, 0, b, 0, 0, 0, 0));
                    break;
                end
                a = 0;
            end else begin
                a++;
            end
        end
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s: got %p expected %p", nm, act, ev);
        end
    endtask

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ev);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) Start2 = v;
        else Start1 = v;
    endtask

    task automatic run(input string nm, input int sel, input int lat, input logic lp, input int cap,
                       input int poke, output int ce_n, output int en_n, output int dn_n);
        obs_t act;
        exp_t e;
        build(lat, lp, cap);
        ce_n = 0;
        en_n = 0;
        dn_n = 0;
        @(negedge CLK);
        set_start(sel, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            act = (sel == 1) ? obs2 : obs1;
            e = exp_q[i];
            ce_n += int'(act.ce);
            en_n += int'(act.en);
            dn_n += int'(act.done);
            if (!e.ca) act.addr = e.o.addr;
            if (!e.cb) act.bin = e.o.bin;
            chk($sformatf("%s_cyc%0d", nm, i), act, e.o);
            set_start(sel, i == poke && i < exp_q.size() - 2);
        end
        set_start(sel, 1'b0);
        if (lp) begin
            Stop = 1'b1;
            @(negedge CLK);
            act = (sel == 1) ? obs2 : obs1;
            Stop = 1'b0;
            chk({nm, "_stop"}, act, {4'd0, 1'b0, 1'b0, 1'b0, act.bin, 1'b0, 1'b1});
        end
    endtask

    vec_t tbl[5];
    int ce_n, en_n, dn_n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{64'h0000_0000_0000_FB73, 4, 48, 1};
        tbl[1] = '{64'h0000_0000_0000_0F5C, 3, 16, 1};
        tbl[2] = '{64'h2222_2222_2222_2222, 16, 256, 1};
        tbl[3] = '{64'h0000_0000_0000_000F, 1, 0, 1};
        tbl[4] = '{64'h0000_0000_0000_FEDC, 4, 0, 1};
        RST = 1'b1;
        Start1 = 1'b0;
        Start2 = 1'b0;
        Stop = 1'b0;
        Loop = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        repeat (2) @(negedge CLK);
        chk("reset_dut1", obs1, 13'd0);
        chk("reset_dut2", obs2, 13'd0);
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) mem[i] = tbl[k].prog[i*4 +: 4];
            run($sformatf("tbl%0d", k), 0, 1, 1'b0, 2000, (k == 0) ? 30 : -1, ce_n, en_n, dn_n);
            ck($sformatf("tbl%0d_ce_pulses", k), ce_n, tbl[k].ce_n);
            ck($sformatf("tbl%0d_en_cycles", k), en_n, tbl[k].en_n);
            ck($sformatf("tbl%0d_done_pulses", k), dn_n, tbl[k].dn_n);
        end
        for (int i = 0; i < 16; i++) mem[i] = tbl[0].prog[i*4 +: 4];
        run("lat2", 1, 2, 1'b0, 2000, -1, ce_n, en_n, dn_n);
        ck("lat2_en_cycles", en_n, 48);
        for (int i = 0; i < 16; i++) mem[i] = 4'd2;
        Loop = 1'b1;
        run("loop", 0, 1, 1'b1, 16 * 22 + 30, 40, ce_n, en_n, dn_n);
        ck("loop_no_done", dn_n, 0);
        Loop = 1'b0;
        // stop at the fifth NOTE cycle
        for (int i = 0; i < 16; i++) mem[i] = tbl[0].prog[i*4 +: 4];
        @(negedge CLK);
        Start1 = 1'b1;
        @(negedge CLK);
        Start1 = 1'b0;
        for (int i = 0; i < 50 && !EN1; i++) @(negedge CLK);
        ck("stop_en_seen", EN1, 1);
        repeat (4) @(negedge CLK);
        Stop = 1'b1;
        @(negedge CLK);
        Stop = 1'b0;
        chk("stop_note_abort", obs1, {4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1});
        @(negedge CLK);
        chk("stop_note_after", obs1, {4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0});
        // reset while waiting on SRAM data
        Start1 = 1'b1;
        @(negedge CLK);
        Start1 = 1'b0;
        ck("rst_read_ce", CE1, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_wait_abort", obs1, 13'd0);
        @(negedge CLK);
        ck("rst_no_done", Done1, 0);
        run("rst_replay", 0, 1, 1'b0, 2000, -1, ce_n, en_n, dn_n);
        // Start and Stop together in IDLE
        Start1 = 1'b1;
        Stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ck($sformatf("startstop_ce%0d", i), {CE1, Busy1}, 0);
        end
        Start1 = 1'b0;
        Stop = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) != 0) mem[$urandom_range(0, 15)] = 4'd15;
            run($sformatf("rnd%0d", r), r % 2, 1 + r % 2, 1'b0, 2000, int'($urandom_range(5, 60)),
                ce_n, en_n, dn_n);
            ck($sformatf("rnd%0d_done", r), dn_n, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
